// File: rtl/alu_pkg.sv
// Shared definitions for the ALU64bit front end: widths, opcode encodings
// and the opcode legality check.
package alu_pkg;

    localparam int DATA_W  = 64;
    localparam int RADDR_W = 5;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_SRA  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_EQ   = 4'b1110;
    localparam logic [3:0] OP_NE   = 4'b1111;

    // Holes in the encoding space that ALU64bit does not implement.
    function automatic logic is_legal_op(input logic [3:0] op);
        return !(op == 4'b0011 || op == 4'b0110 || op == 4'b0111);
    endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Per-source operand resolution: r0 is zero, then ALU result forward,
// then writeback forward, then the regfile read.
module alu_fwd_mux #(
    parameter int DATA_W  = 64,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] rs,
    input  logic [DATA_W-1:0]  rf_data,
    input  logic               fwd_ex_valid,
    input  logic [RADDR_W-1:0] fwd_ex_rd,
    input  logic [DATA_W-1:0]  fwd_ex_data,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic [DATA_W-1:0]  operand
);

    always_comb begin
        operand = rf_data;
        if (rs == '0)
            operand = '0;
        else if (fwd_ex_valid && fwd_ex_rd == rs)
            operand = fwd_ex_data;
        else if (wb_we && wb_rd == rs)
            operand = wb_data;
    end

endmodule

// File: rtl/alu_operand_issue.sv
// Issue slot in front of ALU64bit: resolves operands with forwarding,
// stalls on RAW hazards against the occupant, and counts issues and bubbles.
module alu_operand_issue #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int RADDR_W = alu_pkg::RADDR_W,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_opcode,
    input  logic [RADDR_W-1:0] in_rs1,
    input  logic [RADDR_W-1:0] in_rs2,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]  in_rs1_data,
    input  logic [DATA_W-1:0]  in_rs2_data,
    input  logic               in_use_imm,
    input  logic [DATA_W-1:0]  in_imm,
    input  logic               flush,
    input  logic               fwd_ex_valid,
    input  logic [RADDR_W-1:0] fwd_ex_rd,
    input  logic [DATA_W-1:0]  fwd_ex_data,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  alu_A,
    output logic [DATA_W-1:0]  alu_B,
    output logic [3:0]         alu_opcode,
    output logic [RADDR_W-1:0] out_rd,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   issue_count,
    output logic [CNT_W-1:0]   stall_count
);

    import alu_pkg::*;

    logic               vld_p1;
    logic [DATA_W-1:0]  a_p1;
    logic [DATA_W-1:0]  b_p1;
    logic [3:0]         op_p1;
    logic [RADDR_W-1:0] rd_p1;
    logic               illegal_p1;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   stall_cnt;

    logic [DATA_W-1:0]  rs1_op_p0;
    logic [DATA_W-1:0]  rs2_op_p0;
    logic [DATA_W-1:0]  b_p0;
    logic               hazard_p0;
    logic               accept_p0;
    logic               stall_evt_p0;

    // Stage 0: decode-side operand resolution and handshake
    alu_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_mux_rs1 (
        .rs(in_rs1), .rf_data(in_rs1_data),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .operand(rs1_op_p0)
    );

    alu_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_mux_rs2 (
        .rs(in_rs2), .rf_data(in_rs2_data),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .operand(rs2_op_p0)
    );

    assign b_p0 = in_use_imm ? in_imm : rs2_op_p0;

    // The occupant's result is not forwardable until it leaves the ALU.
    assign hazard_p0 = vld_p1 && (rd_p1 != '0) &&
                       ((rd_p1 == in_rs1) || ((rd_p1 == in_rs2) && !in_use_imm));
    assign in_ready     = !flush && !hazard_p0 && (!vld_p1 || out_ready);
    assign accept_p0    = in_valid && in_ready;
    assign stall_evt_p0 = in_valid && hazard_p0 && out_ready && !flush;

    // Stage 1: issue slot and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            a_p1       <= '0;
            b_p1       <= '0;
            op_p1      <= 4'b0000;
            rd_p1      <= '0;
            illegal_p1 <= 1'b0;
            issue_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            illegal_p1 <= 1'b0;
            if (vld_p1 && out_ready)
                issue_cnt <= issue_cnt + CNT_W'(1);
            if (stall_evt_p0 && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);

            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (accept_p0) begin
                if (is_legal_op(in_opcode)) begin
                    vld_p1 <= 1'b1;
                    a_p1   <= rs1_op_p0;
                    b_p1   <= b_p0;
                    op_p1  <= in_opcode;
                    rd_p1  <= in_rd;
                end else begin
                    vld_p1     <= 1'b0;
                    illegal_p1 <= 1'b1;
                end
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid   = vld_p1;
    assign alu_A       = a_p1;
    assign alu_B       = b_p1;
    assign alu_opcode  = op_p1;
    assign out_rd      = rd_p1;
    assign illegal_op  = illegal_p1;
    assign issue_count = issue_cnt;
    assign stall_count = stall_cnt;

endmodule
